gelu_poly_term_pipe: RTL and testbench
======================================

# gelu_poly_term_pipe

Multi-lane, parametrised successor to the single-lane GELU cubic stage. It computes either x³ or the GELU tanh argument term x + c·x³ in signed fixed point, with saturation and per-lane overflow flags. It is a 3-stage pipeline with valid/ready backpressure, and feeds the tanh approximation stage of the GELU datapath.

## Interface
Parameters:
- DATA_WIDTH, 24: signed fixed-point word width per lane.
- FRAC_BITS, 16: fractional bits; format is Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- LANES, 4: parallel independent lanes.
- COEF, 2930: cubic coefficient in the same Q format (round(0.044715·2^16) = 0x000B72).

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- x_in  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- mode_in  in  1  0 = output x³; 1 = output x + COEF·x³. Travels with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- y_out  out  LANES*DATA_WIDTH  per-lane result, same packing as x_in.
- ovf_out  out  LANES  per-lane saturation flag, aligned with y_out.
- clr_ovf  in  1  clears ovf_sticky.
- ovf_sticky  out  1  OR of every ovf_out bit delivered since the last clear or reset.

## Operation
- **Stage 1:** sq = x·x (2·DATA_WIDTH signed), shifted right by FRAC_BITS, saturated to DATA_WIDTH to form x2. x and mode are delayed alongside.
- **Stage 2:** cb = x2·x_d, shifted right by FRAC_BITS, saturated to form x3.
- **Stage 3:**
  - mode 0: y = x3.
  - mode 1: y = sat(x_dd + ((COEF·x3) >>> FRAC_BITS)), computed with a one-bit-wider add before saturation.
- **Saturation:** clamp to 0x7FF…F or 0x800…0.
- **Lane overflow flag:** a lane's ovf is the OR of all saturation events on that lane across stages 1–3, carried with the data.
- **Shift rule:** arithmetic right shift (floor) unless the rounding feature is enabled (see Configuration).
- **Lane independence:** lanes share valid/ready and mode, and are otherwise fully independent.
- **ovf_sticky:** set when out_valid & out_ready and |ovf_out.
  - clr_ovf clears it.
  - If clr_ovf coincides with a new overflowing handshake, the set wins (ovf_sticky = 1).

## Timing
- **Reset:** rst = 1 at a clock edge clears all stage valids, out_valid = 0, ovf_out = 0, y_out = 0, ovf_sticky = 0. in_ready = 1 in the cycle after reset.
- **Reset mid-operation:** in-flight beats are discarded and none emerge afterwards.
- **Pipeline advance:** global enable adv = ~out_valid | out_ready. in_ready = adv (combinational from out_valid/out_ready).
- **Input acceptance:** a beat is accepted at an edge where in_valid & in_ready.
- **Latency:** 3 cycles when unstalled; a beat accepted at edge N gives out_valid = 1 after edge N+3.
- **Throughput:** 1 beat per cycle.
- **Stall:** when out_valid & ~out_ready, all stage registers, y_out and ovf_out hold, and in_ready = 0.
- **Bubbles:** bubbles propagate as stage-valid = 0. A bubble stage still advances on adv, with no compaction.
- **Output handshake:** out_valid stays high until out_ready is seen. There is no combinational path from in_valid to out_valid.

## Configuration
- **GELU_POLY_ROUND_EN defined:** every >>> FRAC_BITS first adds 2^(FRAC_BITS-1) (round half toward +∞), applied before saturation.
- **Undefined:** plain arithmetic-shift truncation.
- Latency and interface are identical in both builds.

## Test plan
- **Exact values, mode 0:** lane values 0.5 (0x008000), −1.0 (0xFF0000), 4.0 (0x040000), 0 → y = 0x002000, 0xFF0000, 0x400000, 0x000000. All ovf_out = 0; out_valid rises 3 cycles after acceptance.
- **Saturation:** x = 8.0 (0x080000) and −8.0 (0xF80000), mode 0 → y = 0x7FFFFF and 0x800000, ovf_out = 1 on those lanes, ovf_sticky = 1. A following clr_ovf pulse → ovf_sticky = 0.
- **Mode 1:** x = 1.0 (0x010000) → y = 0x010B72. x = −1.0 → y = 0xFEF48E.
- **Rounding:** x = 0x00199A (≈0.1), mode 0 → y = 0x000041 without GELU_POLY_ROUND_EN, 0x000042 with it.
- **Backpressure:** 8 back-to-back beats with out_ready toggling randomly → all 8 results delivered in order, none dropped or duplicated, y_out stable while stalled.
- **Reset mid-flight:** 2 beats in the pipe, then rst pulsed one cycle → out_valid stays 0 until a new beat is accepted, which emerges 3 cycles later.

Source files
------------

// File: rtl/gelu_poly_term_pipe.sv
// Multi-lane 3-stage x^3 / (x + COEF*x^3) fixed-point pipeline with saturation and overflow flags.
// Define GELU_POLY_ROUND_EN to round (half toward +inf) every >>> FRAC_BITS instead of flooring.
module gelu_poly_term_pipe #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned LANES      = 4,
  parameter int          COEF       = 2930
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] x_in,
  input  logic                        mode_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] y_out,
  output logic [LANES-1:0]            ovf_out,
  input  logic                        clr_ovf,
  output logic                        ovf_sticky
);

  // Wide enough to hold any product of two lane words without wrapping.
  localparam int unsigned WideW = 2 * DATA_WIDTH + 1;

  localparam logic signed [WideW-1:0] SatMax =
      {{(WideW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [WideW-1:0] SatMin = ~SatMax;
  localparam logic signed [WideW-1:0] CoefW  = WideW'(COEF);

`ifdef GELU_POLY_ROUND_EN
  localparam logic signed [WideW-1:0] RoundHalf = WideW'(1) << (FRAC_BITS - 1);
`endif

  function automatic logic signed [WideW-1:0] widen(input logic [DATA_WIDTH-1:0] a);
    return {{(WideW - DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [WideW-1:0] frac_shr(input logic signed [WideW-1:0] v);
`ifdef GELU_POLY_ROUND_EN
    return (v + RoundHalf) >>> FRAC_BITS;
`else
    return v >>> FRAC_BITS;
`endif
  endfunction

  function automatic logic out_of_range(input logic signed [WideW-1:0] v);
    return (v > SatMax) || (v < SatMin);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [WideW-1:0] v);
    if (v > SatMax) begin
      return SatMax[DATA_WIDTH-1:0];
    end else if (v < SatMin) begin
      return SatMin[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  logic adv;

  // Stage 0: captured input beat.
  logic                  s0_valid_q, s0_mode_q;
  logic [DATA_WIDTH-1:0] s0_x_q [LANES];

  // Stage 1: x^2.
  logic                  s1_valid_q, s1_mode_q;
  logic [DATA_WIDTH-1:0] s1_x_q  [LANES];
  logic [DATA_WIDTH-1:0] s1_x2_q [LANES];
  logic [DATA_WIDTH-1:0] s1_x2_d [LANES];
  logic [LANES-1:0]      s1_ovf_q, s1_ovf_d;

  // Stage 2: x^3.
  logic                  s2_valid_q, s2_mode_q;
  logic [DATA_WIDTH-1:0] s2_x_q  [LANES];
  logic [DATA_WIDTH-1:0] s2_x3_q [LANES];
  logic [DATA_WIDTH-1:0] s2_x3_d [LANES];
  logic [LANES-1:0]      s2_ovf_q, s2_ovf_d;

  // Stage 3: output register.
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] y_q [LANES];
  logic [DATA_WIDTH-1:0] y_d [LANES];
  logic [LANES-1:0]      ovf_q, ovf_d;
  logic                  ovf_sticky_q;

  logic signed [WideW-1:0] sq_sh   [LANES];
  logic signed [WideW-1:0] cb_sh   [LANES];
  logic signed [WideW-1:0] term_sh [LANES];
  logic signed [WideW-1:0] sum_w   [LANES];

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sq_sh[k]    = '0;
      sq_sh[k]    = frac_shr(widen(s0_x_q[k]) * widen(s0_x_q[k]));
      s1_x2_d[k]  = clamp(sq_sh[k]);
      s1_ovf_d[k] = out_of_range(sq_sh[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      cb_sh[k]    = '0;
      cb_sh[k]    = frac_shr(widen(s1_x2_q[k]) * widen(s1_x_q[k]));
      s2_x3_d[k]  = clamp(cb_sh[k]);
      s2_ovf_d[k] = s1_ovf_q[k] | out_of_range(cb_sh[k]);
    end
  end

  // The scaled cubic term is clamped to a lane word before the add so the
  // sum itself never needs more than one extra bit of headroom.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      term_sh[k] = '0;
      sum_w[k]   = '0;
      y_d[k]     = s2_x3_q[k];
      ovf_d[k]   = s2_ovf_q[k];
      term_sh[k] = frac_shr(CoefW * widen(s2_x3_q[k]));
      sum_w[k]   = widen(s2_x_q[k]) + widen(clamp(term_sh[k]));
      if (s2_mode_q) begin
        y_d[k]   = clamp(sum_w[k]);
        ovf_d[k] = s2_ovf_q[k] | out_of_range(term_sh[k]) | out_of_range(sum_w[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_mode_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_ovf_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_ovf_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
      for (int k = 0; k < LANES; k++) begin
        s0_x_q[k]  <= '0;
        s1_x_q[k]  <= '0;
        s1_x2_q[k] <= '0;
        s2_x_q[k]  <= '0;
        s2_x3_q[k] <= '0;
        y_q[k]     <= '0;
      end
    end else if (adv) begin
      s0_valid_q  <= in_valid;
      s0_mode_q   <= mode_in;
      s1_valid_q  <= s0_valid_q;
      s1_mode_q   <= s0_mode_q;
      s1_ovf_q    <= s1_ovf_d;
      s2_valid_q  <= s1_valid_q;
      s2_mode_q   <= s1_mode_q;
      s2_ovf_q    <= s2_ovf_d;
      out_valid_q <= s2_valid_q;
      ovf_q       <= ovf_d;
      for (int k = 0; k < LANES; k++) begin
        s0_x_q[k]  <= x_in[k*DATA_WIDTH +: DATA_WIDTH];
        s1_x_q[k]  <= s0_x_q[k];
        s1_x2_q[k] <= s1_x2_d[k];
        s2_x_q[k]  <= s1_x_q[k];
        s2_x3_q[k] <= s2_x3_d[k];
        y_q[k]     <= y_d[k];
      end
    end
  end

  // A set on an overflowing handshake takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (out_valid_q && out_ready && (|ovf_q)) begin
      ovf_sticky_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky_q <= 1'b0;
    end
  end

  always_comb begin
    y_out = '0;
    for (int k = 0; k < LANES; k++) begin
      y_out[k*DATA_WIDTH +: DATA_WIDTH] = y_q[k];
    end
  end

  assign out_valid  = out_valid_q;
  assign ovf_out    = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_gelu_poly_term_pipe.sv
// Directed self-checking bench for gelu_poly_term_pipe (default parameters).
module tb_gelu_poly_term_pipe;

  localparam int W = 24;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] x_in;
  logic           mode_in;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] y_out;
  logic [L-1:0]   ovf_out;
  logic           clr_ovf;
  logic           ovf_sticky;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gelu_poly_term_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .mode_in    (mode_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_out      (y_out),
    .ovf_out    (ovf_out),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack4(input logic [23:0] l0, input logic [23:0] l1,
                                        input logic [23:0] l2, input logic [23:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat with out_ready held high and waits (bounded) for its result.
  task automatic run_beat(input logic [95:0] x, input logic mode,
                          output logic [95:0] y, output logic [3:0] ovf, output int lat);
    check_eq("ready_before_send", 96'(in_ready), 96'(1));
    in_valid = 1'b1;
    x_in     = x;
    mode_in  = mode;
    tick();
    in_valid = 1'b0;
    x_in     = '0;
    mode_in  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    y   = y_out;
    ovf = ovf_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] y;
    logic [3:0]  ovf;
    int          lat;
    logic [95:0] vec  [8];
    logic [95:0] expv [8];
    int          n;
    int          sent, recv, cyc;
    logic        acc, cons, held_valid, seen;
    logic [95:0] held_y;
    logic [23:0] exp_round;
    logic [23:0] exp_big;

    rst       = 1'b1;
    in_valid  = 1'b0;
    x_in      = '0;
    mode_in   = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_out_valid", 96'(out_valid), 96'(0));
    check_eq("rst_y_out", y_out, 96'(0));
    check_eq("rst_ovf_out", 96'(ovf_out), 96'(0));
    check_eq("rst_sticky", 96'(ovf_sticky), 96'(0));
    check_eq("rst_in_ready", 96'(in_ready), 96'(1));

    // Exact cubes
    run_beat(pack4(24'h008000, 24'hFF0000, 24'h040000, 24'h000000), 1'b0, y, ovf, lat);
    check_eq("m0_latency", 96'(lat), 96'(3));
    check_eq("m0_y", y, pack4(24'h002000, 24'hFF0000, 24'h400000, 24'h000000));
    check_eq("m0_ovf", 96'(ovf), 96'(0));
    tick();
    check_eq("m0_drained", 96'(out_valid), 96'(0));
    check_eq("m0_sticky", 96'(ovf_sticky), 96'(0));

    // Saturation both directions
    run_beat(pack4(24'h080000, 24'hF80000, 24'h008000, 24'h000000), 1'b0, y, ovf, lat);
    check_eq("sat_y", y, pack4(24'h7FFFFF, 24'h800000, 24'h002000, 24'h000000));
    check_eq("sat_ovf", 96'(ovf), 96'(4'b0011));
    check_eq("sat_sticky_pre", 96'(ovf_sticky), 96'(0));
    tick();
    check_eq("sat_sticky_set", 96'(ovf_sticky), 96'(1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("sat_sticky_clr", 96'(ovf_sticky), 96'(0));

    // GELU argument term; lane 2 saturates in the cube and carries the flag
`ifdef GELU_POLY_ROUND_EN
    exp_big = 24'h0DB900;
`else
    exp_big = 24'h0DB8FF;
`endif
    run_beat(pack4(24'h010000, 24'hFF0000, 24'h080000, 24'h000000), 1'b1, y, ovf, lat);
    check_eq("m1_latency", 96'(lat), 96'(3));
    check_eq("m1_y", y, pack4(24'h010B72, 24'hFEF48E, exp_big, 24'h000000));
    check_eq("m1_ovf", 96'(ovf), 96'(4'b0100));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("set_beats_clr", 96'(ovf_sticky), 96'(1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("clr_after_set", 96'(ovf_sticky), 96'(0));

    // Shift rounding behaviour
`ifdef GELU_POLY_ROUND_EN
    exp_round = 24'h000042;
`else
    exp_round = 24'h000041;
`endif
    run_beat(pack4(24'h00199A, 24'h000000, 24'h000000, 24'h000000), 1'b0, y, ovf, lat);
    check_eq("round_y", y, pack4(exp_round, 24'h000000, 24'h000000, 24'h000000));
    check_eq("round_ovf", 96'(ovf), 96'(0));
    tick();

    // Back-to-back beats of integer cubes under random backpressure
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < L; k++) begin
        n = ((b + k) % 11) - 5;
        vec[b][k*W +: W]  = 24'(n * 65536);
        expv[b][k*W +: W] = 24'(n * n * n * 65536);
      end
    end
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    held_valid = 1'b0;
    held_y     = '0;
    while (recv < 8 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      mode_in   = 1'b0;
      if (sent < 8) begin
        in_valid = 1'b1;
        x_in     = vec[sent];
      end else begin
        in_valid = 1'b0;
        x_in     = '0;
      end
      #1;
      acc  = in_valid & in_ready;
      cons = out_valid & out_ready;
      if (held_valid) begin
        check_eq("stall_valid", 96'(out_valid), 96'(1));
        check_eq("stall_hold", y_out, held_y);
        check_eq("stall_ready", 96'(in_ready), 96'(out_ready));
      end
      if (cons) begin
        check_eq("bp_data", y_out, expv[recv]);
        recv++;
      end
      held_valid = out_valid & ~out_ready;
      held_y     = y_out;
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    check_eq("bp_count", 96'(recv), 96'(8));
    check_eq("bp_no_extra", 96'(out_valid), 96'(0));

    // Reset with two beats in flight
    in_valid = 1'b1;
    x_in     = pack4(24'h010000, 24'h010000, 24'h010000, 24'h010000);
    tick();
    x_in = pack4(24'h020000, 24'h020000, 24'h020000, 24'h020000);
    tick();
    in_valid = 1'b0;
    x_in     = '0;
    rst      = 1'b1;
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check_eq("rst_flight_quiet", 96'(seen), 96'(0));
    check_eq("rst_flight_y", y_out, 96'(0));
    run_beat(pack4(24'h040000, 24'hFF0000, 24'h008000, 24'h000000), 1'b0, y, ovf, lat);
    check_eq("post_rst_latency", 96'(lat), 96'(3));
    check_eq("post_rst_y", y, pack4(24'h400000, 24'hFF0000, 24'h002000, 24'h000000));
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
